// File: rtl/clk_rst_seq.sv
// Reset sequencer and lock supervisor for an MMCM clock generator.
// Optional macro CLK_RST_SEQ_RETRY_CNT_EN adds the saturating o_retry_count output.
module clk_rst_seq #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1000,
  parameter int unsigned STABLE_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_locked,
  output logic       o_mmcm_reset,
  output logic       o_reset,
  output logic       o_locked_sync
`ifdef CLK_RST_SEQ_RETRY_CNT_EN
  ,
  output logic [7:0] o_retry_count
`endif
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_MMCM,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lock_sync;
  logic             locked_s;
  logic             retry_evt;

  assign locked_s      = lock_sync[1];
  assign o_locked_sync = locked_s;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    next_state = state;
    retry_evt  = 1'b0;
    case (state)
      S_RESET_MMCM: begin
        if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          next_state = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state = S_RESET_MMCM;
          retry_evt  = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s)               next_state = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) begin
          next_state = S_RESET_MMCM;
          retry_evt  = 1'b1;
        end
      end
      default: next_state = S_RESET_MMCM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lock_sync    <= 2'b00;
      state        <= S_RESET_MMCM;
      cnt          <= '0;
      o_mmcm_reset <= 1'b1;
      o_reset      <= 1'b1;
    end else begin
      lock_sync <= {lock_sync[0], i_locked};
      state     <= next_state;
      // RUN has no terminal count, so the counter parks at zero there.
      if (next_state != state)  cnt <= '0;
      else if (state != S_RUN)  cnt <= cnt + 1'b1;
      // Outputs are decoded from next_state into flops so they track state without decode glitches.
      o_mmcm_reset <= (next_state == S_RESET_MMCM);
      o_reset      <= (next_state != S_RUN);
    end
  end

`ifdef CLK_RST_SEQ_RETRY_CNT_EN
  logic [7:0] retry_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)                             retry_cnt <= 8'd0;
    else if (retry_evt && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
  end

  assign o_retry_count = retry_cnt;
`else
  logic unused_retry;
  assign unused_retry = retry_evt;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Edge numbers count rising edges after the most recent i_reset release.
module tb_clk_rst_seq;

  logic clk = 1'b0;
  logic i_reset;
  logic i_locked;
  logic o_mmcm_reset;
  logic o_reset;
  logic o_locked_sync;
`ifdef CLK_RST_SEQ_RETRY_CNT_EN
  logic [7:0] o_retry_count;
  `define CHK_RETRY(t, e) check_byte(t, o_retry_count, e)
`else
  `define CHK_RETRY(t, e)
`endif

  int cyc      = 0;
  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  clk_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_locked     (i_locked),
    .o_mmcm_reset (o_mmcm_reset),
    .o_reset      (o_reset),
    .o_locked_sync(o_locked_sync)
`ifdef CLK_RST_SEQ_RETRY_CNT_EN
    ,
    .o_retry_count(o_retry_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s @edge %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset  = 1'b1;
    i_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_mmcm", o_mmcm_reset, 1'b1);
    check_bit("rst_out", o_reset, 1'b1);
    check_bit("rst_sync", o_locked_sync, 1'b0);
    `CHK_RETRY("rst_retry", 8'd0);

    // Power-up: MMCM reset held for 4 cycles after release.
    i_reset = 1'b0;
    cyc     = 0;
    for (int e = 1; e <= 4; e++) begin
      run_to(e);
      check_bit("pwr_mmcm", o_mmcm_reset, e < 4);
      check_bit("pwr_rst", o_reset, 1'b1);
    end

    // Normal lock: first sampled at edge 10, released after edge 20.
    run_to(9);
    check_bit("lock_sync_pre", o_locked_sync, 1'b0);
    i_locked = 1'b1;
    run_to(10);
    check_bit("lock_sync_e10", o_locked_sync, 1'b0);
    run_to(11);
    check_bit("lock_sync_e11", o_locked_sync, 1'b1);
    run_to(19);
    check_bit("lock_rst_e19", o_reset, 1'b1);
    check_bit("lock_mmcm_e19", o_mmcm_reset, 1'b0);
    run_to(20);
    check_bit("lock_rst_e20", o_reset, 1'b0);
    check_bit("lock_mmcm_e20", o_mmcm_reset, 1'b0);
    `CHK_RETRY("lock_retry", 8'd0);

    // Lock loss in RUN: i_locked sampled low at edge 23.
    run_to(22);
    i_locked = 1'b0;
    run_to(24);
    check_bit("loss_rst_e24", o_reset, 1'b0);
    run_to(25);
    check_bit("loss_rst_e25", o_reset, 1'b1);
    check_bit("loss_mmcm_e25", o_mmcm_reset, 1'b1);
    `CHK_RETRY("loss_retry", 8'd1);
    run_to(28);
    check_bit("loss_mmcm_e28", o_mmcm_reset, 1'b1);
    run_to(29);
    check_bit("loss_mmcm_e29", o_mmcm_reset, 1'b0);
    run_to(30);
    i_locked = 1'b1;
    run_to(40);
    check_bit("relock_rst_e40", o_reset, 1'b1);
    run_to(41);
    check_bit("relock_rst_e41", o_reset, 1'b0);
    `CHK_RETRY("relock_retry", 8'd1);

    // Reset from RUN, then timeouts with i_locked held low.
    i_reset  = 1'b1;
    i_locked = 1'b0;
    run_to(43);
    check_bit("rerst_mmcm", o_mmcm_reset, 1'b1);
    check_bit("rerst_sync", o_locked_sync, 1'b0);
    `CHK_RETRY("rerst_retry", 8'd0);
    i_reset = 1'b0;
    cyc     = 0;
    run_to(23);
    check_bit("to_mmcm_e23", o_mmcm_reset, 1'b0);
    run_to(24);
    check_bit("to_mmcm_e24", o_mmcm_reset, 1'b1);
    `CHK_RETRY("to_retry_e24", 8'd1);
    run_to(27);
    check_bit("to_mmcm_e27", o_mmcm_reset, 1'b1);
    run_to(28);
    check_bit("to_mmcm_e28", o_mmcm_reset, 1'b0);
    run_to(47);
    check_bit("to_mmcm_e47", o_mmcm_reset, 1'b0);
    run_to(48);
    check_bit("to_mmcm_e48", o_mmcm_reset, 1'b1);
    `CHK_RETRY("to_retry_e48", 8'd2);
    run_to(72);
    check_bit("to_mmcm_e72", o_mmcm_reset, 1'b1);
    check_bit("to_rst_e72", o_reset, 1'b1);
    `CHK_RETRY("to_retry_e72", 8'd3);

    // Lock arriving on the timeout cycle wins; then a one-cycle dropout.
    run_to(93);
    i_locked = 1'b1;
    run_to(96);
    check_bit("tie_mmcm_e96", o_mmcm_reset, 1'b0);
    `CHK_RETRY("tie_retry_e96", 8'd3);
    run_to(98);
    i_locked = 1'b0;
    run_to(99);
    i_locked = 1'b1;
    run_to(100);
    check_bit("glitch_sync_e100", o_locked_sync, 1'b0);
    run_to(101);
    check_bit("glitch_sync_e101", o_locked_sync, 1'b1);
    check_bit("glitch_mmcm_e101", o_mmcm_reset, 1'b0);
    run_to(104);
    check_bit("glitch_rst_e104", o_reset, 1'b1);
    run_to(109);
    check_bit("glitch_rst_e109", o_reset, 1'b1);
    check_bit("glitch_mmcm_e109", o_mmcm_reset, 1'b0);
    run_to(110);
    check_bit("glitch_rst_e110", o_reset, 1'b0);
    `CHK_RETRY("glitch_retry", 8'd3);

    // Second lock loss; lock during RESET_MMCM is ignored; then reset in STABLE.
    run_to(111);
    i_locked = 1'b0;
    run_to(113);
    check_bit("loss2_rst_e113", o_reset, 1'b0);
    run_to(114);
    check_bit("loss2_rst_e114", o_reset, 1'b1);
    check_bit("loss2_mmcm_e114", o_mmcm_reset, 1'b1);
    `CHK_RETRY("loss2_retry", 8'd4);
    i_locked = 1'b1;
    run_to(117);
    check_bit("loss2_mmcm_e117", o_mmcm_reset, 1'b1);
    run_to(118);
    check_bit("loss2_mmcm_e118", o_mmcm_reset, 1'b0);
    run_to(121);
    check_bit("stable_rst_e121", o_reset, 1'b1);
    check_bit("stable_sync_e121", o_locked_sync, 1'b1);
    i_reset = 1'b1;
    run_to(122);
    check_bit("midrst_mmcm", o_mmcm_reset, 1'b1);
    check_bit("midrst_rst", o_reset, 1'b1);
    check_bit("midrst_sync", o_locked_sync, 1'b0);
    `CHK_RETRY("midrst_retry", 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
